// File: rtl/alu_seq_pkg.sv
// Shared constants and state encoding for the ALU command sequencer.
// Command codes, error code, function width and the 3-bit FSM encoding.
package alu_seq_pkg;

  localparam int FUN_W = 4;

  localparam logic [7:0] CMD_ALU_OPER = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP  = 8'hDD;
  localparam logic [7:0] ERR_TIMEOUT  = 8'hEE;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_A    = 3'd1,
    GET_B    = 3'd2,
    GET_FUN  = 3'd3,
    ALU_RUN  = 3'd4,
    WAIT_RES = 3'd5,
    SEND_LSB = 3'd6,
    SEND_MSB = 3'd7
  } state_t;

endpackage

// File: rtl/alu_seq_watchdog.sv
// WAIT_RES timeout counter for the ALU command sequencer.
// Counts while run is high, clears whenever run drops.
module alu_seq_watchdog #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  assign expired = run && (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run) begin
      cnt <= '0;
    end else if (!expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Byte-stream command sequencer driving the ALU and returning results to TX.
// Optional WAIT_RES timeout enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  input  logic                    FIFO_FULL,
  output logic [DATA_WIDTH-1:0]   ALU_OP_A,
  output logic [DATA_WIDTH-1:0]   ALU_OP_B,
  output logic [FUN_W-1:0]        ALU_FUN,
  output logic                    ALU_EN,
  output logic                    ALU_CLK_EN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  output logic                    BUSY
);

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  state_t state;
  state_t state_nx;

  logic [2*DATA_WIDTH-1:0] res;
  logic                    timeout;
  logic                    is_oper;
  logic                    is_nop;

  assign is_oper = (RX_P_DATA == DATA_WIDTH'(CMD_ALU_OPER));
  assign is_nop  = (RX_P_DATA == DATA_WIDTH'(CMD_ALU_NOP));

`ifdef ALU_SEQ_TIMEOUT_EN
  alu_seq_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (CLK),
    .rst_n   (RST),
    .run     (state == WAIT_RES),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (RX_D_VLD && is_oper) begin
          state_nx = GET_A;
        end else if (RX_D_VLD && is_nop) begin
          state_nx = GET_FUN;
        end
      end
      GET_A:    if (RX_D_VLD) state_nx = GET_B;
      GET_B:    if (RX_D_VLD) state_nx = GET_FUN;
      GET_FUN:  if (RX_D_VLD) state_nx = ALU_RUN;
      ALU_RUN:  state_nx = WAIT_RES;
      WAIT_RES: if (ALU_OUT_VLD || timeout) state_nx = SEND_LSB;
      SEND_LSB: if (!FIFO_FULL) state_nx = SEND_MSB;
      SEND_MSB: if (!FIFO_FULL) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ALU_OP_A   <= '0;
      ALU_OP_B   <= '0;
      ALU_FUN    <= '0;
      ALU_EN     <= 1'b0;
      ALU_CLK_EN <= 1'b0;
      TX_P_DATA  <= '0;
      TX_D_VLD   <= 1'b0;
      BUSY       <= 1'b0;
      res        <= '0;
    end else begin
      ALU_EN     <= (state_nx == ALU_RUN);
      ALU_CLK_EN <= (state_nx == ALU_RUN) || (state_nx == WAIT_RES);
      BUSY       <= (state_nx != IDLE);
      TX_D_VLD   <= 1'b0;
      if (RX_D_VLD && state == GET_A) begin
        ALU_OP_A <= RX_P_DATA;
      end
      if (RX_D_VLD && state == GET_B) begin
        ALU_OP_B <= RX_P_DATA;
      end
      if (RX_D_VLD && state == GET_FUN) begin
        ALU_FUN <= RX_P_DATA[FUN_W-1:0];
      end
      if (state == WAIT_RES && ALU_OUT_VLD) begin
        res <= ALU_OUT;
      end else if (state == WAIT_RES && timeout) begin
        res <= {{DATA_WIDTH{1'b0}}, DATA_WIDTH'(ERR_TIMEOUT)};
      end
      if (!FIFO_FULL && state == SEND_LSB) begin
        TX_P_DATA <= res[DATA_WIDTH-1:0];
        TX_D_VLD  <= 1'b1;
      end
      if (!FIFO_FULL && state == SEND_MSB) begin
        TX_P_DATA <= res[2*DATA_WIDTH-1:DATA_WIDTH];
        TX_D_VLD  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer.
// Define ALU_SEQ_TIMEOUT_EN to also exercise the timeout path.
module tb_alu_cmd_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic        FIFO_FULL;
  logic [7:0]  ALU_OP_A;
  logic [7:0]  ALU_OP_B;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN;
  logic        ALU_CLK_EN;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        BUSY;

  int         n_chk = 0;
  int         n_err = 0;
  int         tx_cnt = 0;
  int         en_cnt = 0;
  logic       prev_en = 1'b0;
  logic       full_at_edge = 1'b0;
  logic [7:0] exp_q[$];

  alu_cmd_sequencer dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_P_DATA   (RX_P_DATA),
    .RX_D_VLD    (RX_D_VLD),
    .ALU_OUT     (ALU_OUT),
    .ALU_OUT_VLD (ALU_OUT_VLD),
    .FIFO_FULL   (FIFO_FULL),
    .ALU_OP_A    (ALU_OP_A),
    .ALU_OP_B    (ALU_OP_B),
    .ALU_FUN     (ALU_FUN),
    .ALU_EN      (ALU_EN),
    .ALU_CLK_EN  (ALU_CLK_EN),
    .TX_P_DATA   (TX_P_DATA),
    .TX_D_VLD    (TX_D_VLD),
    .BUSY        (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(posedge CLK) full_at_edge = FIFO_FULL;

  always @(negedge CLK) begin
    if (ALU_EN) begin
      en_cnt++;
      check("alu_en_pulse", {31'b0, prev_en}, 0);
    end
    prev_en = ALU_EN;
    if (TX_D_VLD) begin
      tx_cnt++;
      check("tx_while_full", {31'b0, full_at_edge}, 0);
      check("tx_queued", {31'b0, exp_q.size() != 0}, 1);
      if (exp_q.size() != 0) begin
        check("tx_data", {24'b0, TX_P_DATA}, {24'b0, exp_q.pop_front()});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK);
    #1 RX_P_DATA = b;
    RX_D_VLD = 1'b1;
    @(posedge CLK);
    #1 RX_D_VLD = 1'b0;
  endtask

  task automatic alu_reply(input logic [15:0] v);
    @(posedge CLK);
    #1 ALU_OUT = v;
    ALU_OUT_VLD = 1'b1;
    @(posedge CLK);
    #1 ALU_OUT_VLD = 1'b0;
  endtask

  task automatic wait_en();
    int start;
    start = en_cnt;
    for (int i = 0; i < 20 && en_cnt == start; i++) @(negedge CLK);
    check("alu_en_seen", en_cnt - start, 1);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (exp_q.size() == 0 && !BUSY) break;
    end
    check("drain_q", exp_q.size(), 0);
    check("drain_busy", {31'b0, BUSY}, 0);
    check("drain_clk_en", {31'b0, ALU_CLK_EN}, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_a"}, {24'b0, ALU_OP_A}, 0);
    check({tag, "_b"}, {24'b0, ALU_OP_B}, 0);
    check({tag, "_fun"}, {28'b0, ALU_FUN}, 0);
    check({tag, "_en"}, {31'b0, ALU_EN}, 0);
    check({tag, "_clk_en"}, {31'b0, ALU_CLK_EN}, 0);
    check({tag, "_tx"}, {23'b0, TX_D_VLD, TX_P_DATA}, 0);
    check({tag, "_busy"}, {31'b0, BUSY}, 0);
  endtask

  initial begin
    int t0;
    RST = 1'b0;
    RX_P_DATA = '0;
    RX_D_VLD = 1'b0;
    ALU_OUT = '0;
    ALU_OUT_VLD = 1'b0;
    FIFO_FULL = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_zero_outputs("reset");
    @(posedge CLK);
    #1 RST = 1'b1;

    // stray ALU result while idle is ignored
    alu_reply(16'h1234);
    repeat (3) @(negedge CLK);
    check("idle_vld_busy", {31'b0, BUSY}, 0);
    check("idle_vld_tx", tx_cnt, 0);

    // 1: add
    send_byte(8'hCC);
    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'h00);
    wait_en();
    check("t1_a", {24'b0, ALU_OP_A}, 32'h05);
    check("t1_b", {24'b0, ALU_OP_B}, 32'h03);
    check("t1_fun", {28'b0, ALU_FUN}, 0);
    check("t1_busy", {31'b0, BUSY}, 1);
    check("t1_clk_en", {31'b0, ALU_CLK_EN}, 1);
    exp_q.push_back(8'h08);
    exp_q.push_back(8'h00);
    alu_reply(16'h0008);
    drain(20);
    check("t1_en_total", en_cnt, 1);

    // 2: NOP reuses operands
    send_byte(8'hDD);
    send_byte(8'h02);
    wait_en();
    check("t2_a", {24'b0, ALU_OP_A}, 32'h05);
    check("t2_b", {24'b0, ALU_OP_B}, 32'h03);
    check("t2_fun", {28'b0, ALU_FUN}, 2);
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'h00);
    alu_reply(16'h000F);
    drain(20);

    // 3: junk first word, then full command
    send_byte(8'h7A);
    repeat (2) @(negedge CLK);
    check("t3_junk_busy", {31'b0, BUSY}, 0);
    send_byte(8'hCC);
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'hF2);
    wait_en();
    check("t3_a", {24'b0, ALU_OP_A}, 32'hFF);
    check("t3_b", {24'b0, ALU_OP_B}, 32'hFF);
    check("t3_fun", {28'b0, ALU_FUN}, 2);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'hFE);
    alu_reply(16'hFE01);
    drain(20);

    // 4: back-pressure at SEND_LSB
    send_byte(8'hCC);
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h01);
    wait_en();
    FIFO_FULL = 1'b1;
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h00);
    alu_reply(16'h0030);
    t0 = tx_cnt;
    repeat (10) @(negedge CLK);
    check("t4_held_tx", tx_cnt - t0, 0);
    check("t4_held_busy", {31'b0, BUSY}, 1);
    check("t4_held_clk_en", {31'b0, ALU_CLK_EN}, 0);
    @(posedge CLK);
    #1 FIFO_FULL = 1'b0;
    drain(20);
    check("t4_tx_count", tx_cnt - t0, 2);

    // 5: RX dropped in WAIT_RES, then async reset
    send_byte(8'hCC);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    wait_en();
    t0 = tx_cnt;
    send_byte(8'hCC);
    send_byte(8'h44);
    repeat (2) @(negedge CLK);
    check("t5_wait_busy", {31'b0, BUSY}, 1);
    check("t5_wait_clk_en", {31'b0, ALU_CLK_EN}, 1);
    check("t5_wait_a", {24'b0, ALU_OP_A}, 32'h01);
    #2 RST = 1'b0;
    #1 check_zero_outputs("t5_rst");
    @(posedge CLK);
    #1 RST = 1'b1;
    repeat (4) @(negedge CLK);
    check("t5_no_tx", tx_cnt - t0, 0);
    send_byte(8'hDD);
    send_byte(8'h01);
    wait_en();
    check("t5_nop_a", {24'b0, ALU_OP_A}, 0);
    check("t5_nop_b", {24'b0, ALU_OP_B}, 0);
    check("t5_nop_fun", {28'b0, ALU_FUN}, 1);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    alu_reply(16'h0000);
    drain(20);

`ifdef ALU_SEQ_TIMEOUT_EN
    // 6: ALU never answers
    send_byte(8'hCC);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h05);
    wait_en();
    t0 = tx_cnt;
    exp_q.push_back(8'hEE);
    exp_q.push_back(8'h00);
    repeat (200) @(negedge CLK);
    check("t6_early_tx", tx_cnt - t0, 0);
    check("t6_early_clk_en", {31'b0, ALU_CLK_EN}, 1);
    drain(120);
    check("t6_tx_count", tx_cnt - t0, 2);
`endif

    repeat (3) @(negedge CLK);
    check("final_q", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
